// File: rtl/prbs_pkg.sv
// Shared types and standard polynomial constants for the PRBS generator family.
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    // Tap masks: bit i set means state[i] feeds the XOR.
    localparam logic [6:0]  PRBS7_TAPS  = 7'h60;
    localparam logic [8:0]  PRBS9_TAPS  = 9'h110;
    localparam logic [14:0] PRBS15_TAPS = 15'h6000;
    localparam logic [22:0] PRBS23_TAPS = 23'h420000;
    localparam logic [30:0] PRBS31_TAPS = 31'h48000000;

    localparam logic [6:0]  PRBS7_SEED  = 7'h01;
    localparam logic [8:0]  PRBS9_SEED  = 9'h001;
    localparam logic [14:0] PRBS15_SEED = 15'h0001;
    localparam logic [22:0] PRBS23_SEED = 23'h000001;
    localparam logic [30:0] PRBS31_SEED = 31'h00000001;

endpackage

// File: rtl/prbs_gen_lfsr_adv.sv
// Combinational multi-step Fibonacci LFSR advance: DATA_W steps in one cycle,
// first-generated bit lands in word[DATA_W-1]. Reusable by a receive-side checker.
module prbs_lfsr_adv #(
    parameter int                LFSR_W = 7,
    parameter logic [LFSR_W-1:0] TAPS   = 'h60,
    parameter int                DATA_W = 8
) (
    input  logic [LFSR_W-1:0] state,
    output logic [LFSR_W-1:0] next_state,
    output logic [DATA_W-1:0] word
);

    for (genvar k = 0; k < DATA_W; k++) begin : g_step
        logic [LFSR_W-1:0] cur;
        if (k == 0) begin : g_first
            assign cur = state;
        end else begin : g_next
            assign cur = {g_step[k-1].cur[LFSR_W-2:0], ^(g_step[k-1].cur & TAPS)};
        end
        assign word[DATA_W-1-k] = cur[LFSR_W-1];
    end

    assign next_state = {g_step[DATA_W-1].cur[LFSR_W-2:0], ^(g_step[DATA_W-1].cur & TAPS)};

endmodule

// File: rtl/prbs_gen.sv
// Parametrised PRBS word generator with valid/ready output, seed load and lock-up guard.
// Optional PRBS_ERR_INJ_EN adds an err_inj input that flips bit 0 of the next launched word.
module prbs_gen
    import prbs_pkg::*;
#(
    parameter int                LFSR_W = 7,
    parameter logic [LFSR_W-1:0] TAPS   = PRBS7_TAPS,
    parameter logic [LFSR_W-1:0] SEED   = PRBS7_SEED,
    parameter int                DATA_W = 8,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              lockup_err,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              busy
`ifdef PRBS_ERR_INJ_EN
    ,
    input  logic              err_inj
`endif
);

    fsm_t              fsm;
    logic [LFSR_W-1:0] state;
    logic [LFSR_W-1:0] cur_state;
    logic [LFSR_W-1:0] adv_state;
    logic [DATA_W-1:0] adv_word;
    logic [DATA_W-1:0] launch_word;
    logic              state_zero;
    logic              handshake;
    logic              launch;

    // An all-zero LFSR never leaves zero, so it is replaced by SEED before use.
    assign state_zero = (state == '0);
    assign cur_state  = state_zero ? SEED : state;
    assign handshake  = out_valid && out_ready;

    // Enable seen in IDLE launches on the same edge that enters RUN, giving
    // one-cycle latency; with enable low nothing new is launched (drain only).
    assign launch = !seed_load && enable && (!out_valid || out_ready);

    assign busy = (fsm != IDLE);

    prbs_lfsr_adv #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .DATA_W (DATA_W)
    ) u_adv (
        .state      (cur_state),
        .next_state (adv_state),
        .word       (adv_word)
    );

`ifdef PRBS_ERR_INJ_EN
    logic err_pend;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pend <= 1'b0;
        end else if (seed_load) begin
            err_pend <= 1'b0;
        end else if (launch) begin
            err_pend <= err_inj;
        end else if (err_inj) begin
            err_pend <= 1'b1;
        end
    end

    assign launch_word = adv_word ^ DATA_W'(err_pend);
`else
    assign launch_word = adv_word;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SEED;
            out_data   <= '0;
            out_valid  <= 1'b0;
            lockup_err <= 1'b0;
            beat_cnt   <= '0;
            fsm        <= IDLE;
        end else if (seed_load) begin
            state      <= (seed_val == '0) ? SEED : seed_val;
            lockup_err <= (seed_val == '0);
            out_valid  <= 1'b0;
            fsm        <= enable ? RUN : IDLE;
        end else begin
            if (launch) begin
                state     <= adv_state;
                out_data  <= launch_word;
                out_valid <= 1'b1;
            end else begin
                if (state_zero) state <= SEED;
                if (handshake)  out_valid <= 1'b0;
            end

            if (state_zero) lockup_err <= 1'b1;
            if (handshake)  beat_cnt   <= beat_cnt + 1'b1;

            case (fsm)
                IDLE: begin
                    if (enable) fsm <= RUN;
                end
                RUN: begin
                    // A handshake completing this cycle leaves nothing to drain.
                    if (!enable) fsm <= (out_valid && !out_ready) ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (enable)                       fsm <= RUN;
                    else if (handshake || !out_valid) fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_gen.sv
// Self-checking bench for prbs_gen: directed steps plus random back-pressure,
// scored against a bit-sequence model built from the LFSR recurrence.
`timescale 1ns/1ps
module tb_prbs_gen;

  localparam logic [6:0] SEED = 7'h01;
  localparam logic [6:0] TAPS = 7'h60;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        seed_load = 1'b0;
  logic [6:0]  seed_val = '0;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        lockup_err;
  logic [15:0] beat_cnt;
  logic        busy;
`ifdef PRBS_ERR_INJ_EN
  logic        err_inj = 1'b0;
`endif

  logic        enable_b = 1'b0;
  logic [0:0]  data_b;
  logic        valid_b;
  logic        lock_b;
  logic [15:0] cnt_b;
  logic        busy_b;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prbs_gen u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .lockup_err (lockup_err),
    .beat_cnt   (beat_cnt),
    .busy       (busy)
`ifdef PRBS_ERR_INJ_EN
    ,
    .err_inj    (err_inj)
`endif
  );

  prbs_gen #(.DATA_W(1)) u_bit (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable_b),
    .seed_load  (1'b0),
    .seed_val   (7'h00),
    .out_data   (data_b),
    .out_valid  (valid_b),
    .out_ready  (1'b1),
    .lockup_err (lock_b),
    .beat_cnt   (cnt_b),
    .busy       (busy_b)
`ifdef PRBS_ERR_INJ_EN
    ,
    .err_inj    (1'b0)
`endif
  );

  // Reference model: the output bit stream x[] obeys
  // x[n+7] = XOR over set taps i of x[n+6-i], with x[0..6] = seed MSB first.
  bit          m_bits [0:4095];
  int          m_pos;
  bit          m_pend;
  logic [7:0]  exp_data;
  logic        exp_valid;
  logic [15:0] exp_cnt;
  logic        exp_lock;

  function automatic void model_seed(input logic [6:0] s);
    logic [6:0] eff;
    logic [6:0] t;
    bit b;
    t = TAPS;
    eff = (s == 7'h00) ? SEED : s;
    for (int i = 0; i < 7; i++) m_bits[i] = eff[6-i];
    for (int n = 0; n + 7 < 4096; n++) begin
      b = 1'b0;
      for (int i = 0; i < 7; i++) if (t[i]) b = b ^ m_bits[n+6-i];
      m_bits[n+7] = b;
    end
    m_pos = 0;
  endfunction

  function automatic logic [7:0] model_word();
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w = {w[6:0], m_bits[m_pos+i]};
    m_pos = m_pos + 8;
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_seed(SEED);
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_cnt   = '0;
    exp_lock  = 1'b0;
    m_pend    = 1'b0;
  endtask

  // One clock: predict from the pre-edge inputs, then compare after the edge.
  task automatic cycle();
    logic pre_hs;
    logic pre_launch;
    logic pre_load;
    logic inj_pre;
    logic [6:0] pre_seed;
`ifdef PRBS_ERR_INJ_EN
    inj_pre = err_inj;
`else
    inj_pre = 1'b0;
`endif
    pre_hs     = exp_valid && out_ready;
    pre_load   = seed_load;
    pre_seed   = seed_val;
    pre_launch = !seed_load && enable && (!exp_valid || out_ready);
    @(posedge clk);
    #1;
    if (pre_load) begin
      model_seed(pre_seed);
      exp_valid = 1'b0;
      exp_lock  = (pre_seed == 7'h00);
      m_pend    = 1'b0;
    end else begin
      if (pre_hs) exp_cnt = exp_cnt + 16'd1;
      if (pre_launch) begin
        exp_data = model_word();
        if (m_pend) exp_data[0] = ~exp_data[0];
        m_pend    = inj_pre;
        exp_valid = 1'b1;
      end else begin
        if (pre_hs) exp_valid = 1'b0;
        m_pend = m_pend | inj_pre;
      end
    end
    check("valid", out_valid, exp_valid);
    check("beat_cnt", beat_cnt, exp_cnt);
    check("lockup_err", lockup_err, exp_lock);
    if (exp_valid) check("data", out_data, exp_data);
  endtask

  initial begin
    logic [15:0] cnt_before;
    bit          bits [0:253];
    int          bad;
    int          ones;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_lock", lockup_err, 1'b0);
    check("rst_cnt", beat_cnt, 16'd0);
    check("rst_busy", busy, 1'b0);

    // Default stream and 5-cycle stall
    reset_n   = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    cycle();
    check("beat0", out_data, 8'h02);
    check("busy_run", busy, 1'b1);
    cycle();
    check("beat1", out_data, 8'h0C);
    out_ready = 1'b0;
    repeat (5) begin
      cycle();
      check("stall_hold", out_data, 8'h0C);
    end
    out_ready = 1'b1;
    cycle();
    check("beat2", out_data, 8'h28);
    cycle();
    check("cnt3", beat_cnt, 16'd3);

    // Random back-pressure and enable
    repeat (200) begin
      out_ready = 1'($urandom_range(0, 1));
      enable    = ($urandom_range(0, 7) != 0);
      cycle();
    end

    // Zero seed load: substitution and lock-up flag
    enable    = 1'b1;
    out_ready = 1'b0;
    seed_val  = 7'h00;
    seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    check("zero_seed_lock", lockup_err, 1'b1);
    check("zero_seed_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    cycle();
    check("restart_beat0", out_data, 8'h02);
    cycle();
    check("restart_beat1", out_data, 8'h0C);

    // Random non-zero seed clears lock-up
    out_ready = 1'b0;
    seed_val  = 7'($urandom_range(1, 127));
    seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    check("seed_clear_lock", lockup_err, 1'b0);
    repeat (40) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end

    // Drain: enable drops while a word is stalled
    enable    = 1'b1;
    out_ready = 1'b0;
    cycle();
    enable = 1'b0;
    cycle();
    check("drain_busy", busy, 1'b1);
    check("drain_valid", out_valid, 1'b1);
    cnt_before = beat_cnt;
    out_ready = 1'b1;
    cycle();
    check("drain_idle", busy, 1'b0);
    check("drain_cnt", beat_cnt, cnt_before + 16'd1);
    cycle();
    check("idle_quiet", out_valid, 1'b0);

`ifdef PRBS_ERR_INJ_EN
    // Two err_inj pulses coalesce into one flip of the second word
    enable    = 1'b1;
    out_ready = 1'b1;
    seed_val  = SEED;
    seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    cycle();
    check("inj_beat0", out_data, 8'h02);
    out_ready = 1'b0;
    err_inj = 1'b1; cycle();
    err_inj = 1'b0; cycle();
    err_inj = 1'b1; cycle();
    err_inj = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("inj_beat1", out_data, 8'h0D);
    cycle();
    check("inj_beat2", out_data, 8'h28);
`endif

    // Reset mid-stream
    enable    = 1'b1;
    out_ready = 1'b1;
    cycle();
    reset_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 8'h00);
    check("midrst_cnt", beat_cnt, 16'd0);
    check("midrst_busy", busy, 1'b0);
    enable    = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();

    // One bit per beat: period 127, 64/63 balance
    model_seed(SEED);
    enable_b = 1'b1;
    bad = 0;
    for (int i = 0; i < 254; i++) begin
      @(posedge clk);
      #1;
      if (!valid_b) bad++;
      bits[i] = data_b[0];
    end
    @(posedge clk);
    #1;
    check("bit_valid_run", bad, 0);
    check("bit_cnt", cnt_b, 16'd254);
    bad = 0;
    for (int i = 0; i < 254; i++) if (bits[i] != m_bits[i]) bad++;
    check("bit_sequence", bad, 0);
    bad = 0;
    for (int i = 0; i < 127; i++) if (bits[i] != bits[i+127]) bad++;
    check("bit_period", bad, 0);
    ones = 0;
    for (int i = 0; i < 127; i++) if (bits[i]) ones++;
    check("bit_balance", ones, 64);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_gen.md
Name: prbs_gen

Overview:
- Parametrised Fibonacci-LFSR PRBS generator and successor to the single-bit 7-bit PRNG.
- Configurable LFSR length, tap mask and seed.
- Emits DATA_W bits per beat over a valid/ready stream, with runtime seed load, all-zero lock-up protection and a beat counter.
- Feeds link/BERT test paths in place of the 1-bit generator.

Parameters:
- LFSR_W, 7, LFSR length in bits (3..31).
- TAPS, 7'h60, feedback mask; bit i set means state[i] enters the XOR (default x^7+x^6+1).
- SEED, 7'h01, reset/fallback state; must be non-zero.
- DATA_W, 8, bits per output beat (1..64).
- CNT_W, 16, beat counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; run generator.
- seed_load  in  1  single-cycle pulse; load seed_val.
- seed_val  in  LFSR_W  runtime seed.
- out_data  out  DATA_W  PRBS word; MSB is the first-generated bit.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts the word.
- lockup_err  out  1  sticky; an all-zero seed was substituted.
- beat_cnt  out  CNT_W  accepted beats, wraps.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=SEED, out_data=0, out_valid=0, lockup_err=0, beat_cnt=0, FSM=IDLE.
- LFSR single step:
  - Output bit = state[LFSR_W-1].
  - fb = XOR of state[i] for all TAPS[i]=1.
  - state <= {state[LFSR_W-2:0], fb}.
- Word build: DATA_W steps per word, computed combinationally in one cycle.
  - out_data[DATA_W-1] = first step's bit; out_data[0] = last step's bit.
  - LFSR advances by DATA_W steps per launched word.
- Launch: a word is loaded into the output register when the FSM is RUN and (!out_valid or out_ready).
  - out_valid is registered; first beat is valid 1 cycle after enable is sampled high in IDLE.
- Stream rule: while out_valid=1 and out_ready=0, out_data is held stable and the LFSR does not advance.
- Throughput: 1 word per cycle when out_ready is held high.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: enable=1 -> RUN.
  - RUN: enable=0 and out_valid=0 -> IDLE. enable=0 and out_valid=1 -> DRAIN, with no further launches.
  - DRAIN: handshake (out_valid and out_ready) -> IDLE, out_valid=0. enable reasserted -> RUN.
- seed_load has top priority, in any state:
  - Next cycle: state=seed_val, out_valid=0 (pending word discarded, not counted), FSM=RUN if enable else IDLE.
  - seed_val==0: state=SEED and lockup_err=1.
  - A non-zero seed_load clears lockup_err.
- Defensive check: if the LFSR state is ever observed all-zero, substitute SEED and set lockup_err.
- beat_cnt: +1 on each out_valid and out_ready handshake; wraps at 2^CNT_W-1 -> 0.
- busy = (FSM != IDLE).
- Reset mid-stream: immediate return to reset values; no partial word is retained.

Optional Feature:
- Macro PRBS_ERR_INJ_EN.
- Defined:
  - Adds input err_inj (1 bit, pulse).
  - A pending-error flag is set by err_inj.
  - The next launched word has out_data[0] inverted; the flag is then cleared.
  - Multiple pulses before a launch coalesce into one error.
  - LFSR state is unaffected.
  - seed_load clears the pending flag.
- Undefined: no port, no flag, no inversion logic.

Decomposition:
- Package prbs_pkg:
  - FSM state enum (IDLE/RUN/DRAIN).
  - Standard tap constants: PRBS7 7'h60, PRBS9 9'h110, PRBS15 15'h6000, PRBS23 23'h420000, PRBS31 31'h48000000.
  - Matching default seeds.
- Sub-module prbs_lfsr_adv:
  - Combinational.
  - Params LFSR_W, TAPS, DATA_W.
  - Input state; outputs next_state (after DATA_W steps) and word.
  - Generate loop over steps; reusable by a future checker.

Test Plan:
- Reset, enable=1, out_ready=1, defaults -> beats 8'h02, 8'h0C, 8'h28 on consecutive cycles; beat_cnt=3; out_valid high from 1 cycle after enable.
- out_ready=0 for 5 cycles mid-stream -> out_data holds 8'h0C throughout; after ready returns, the next word is 8'h28 (no skip).
- seed_load with seed_val=0 -> lockup_err=1, out_valid=0 next cycle; stream restarts from SEED (first word 8'h02). Non-zero seed_load clears lockup_err.
- enable drops while out_valid=1 and out_ready=0 -> DRAIN, busy=1; one handshake -> IDLE, out_valid=0; beat_cnt +1 only.
- LFSR_W=7, DATA_W=1, run 254 beats -> output sequence has period 127 and a 64-ones/63-zeros balance; beat_cnt=254.
- PRBS_ERR_INJ_EN defined: err_inj pulsed twice before the 2nd launch -> 2nd word 8'h0D, others unchanged; 3rd word 8'h28.
